counter_run_arbiter: RTL

//   Shares one 8-bit counter (enable/load/load_value in, count/overflow out) between
//   NUM_REQ requesters. Each request is a "run": load a start value, then count for
//   a given number of cycles. Requesters are granted round-robin. The block drives
//   the counter's control inputs and returns the final count and an overflow flag.
//   It sits between the requesters and the counter instance.

---
 rtl/counter_run_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/counter_run_arbiter.sv
// counter_run_arbiter: round-robin sharing of one counter between NUM_REQ requesters.
// Each granted request loads a start value into the counter, enables it for a given
// number of cycles, then returns the final count, the requester id and an overflow flag.
module counter_run_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned LEN_W   = 8,
   localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_start,
   input  logic [NUM_REQ*LEN_W-1:0] req_len,
   output logic                     ctr_enable,
   output logic                     ctr_load,
   output logic [WIDTH-1:0]         ctr_load_value,
   input  logic [WIDTH-1:0]         ctr_count,
   input  logic                     ctr_overflow,
   output logic                     done_valid,
   input  logic                     done_ready,
   output logic [ID_W-1:0]          done_id,
   output logic [WIDTH-1:0]         done_count,
   output logic                     done_overflow,
   output logic                     busy
);

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

   state_e           state_q;
   logic [ID_W-1:0]  rr_ptr_q;
   logic [ID_W-1:0]  id_q;
   logic [WIDTH-1:0] start_q;
   logic [WIDTH-1:0] count_q;
   logic [LEN_W-1:0] remain_q;
   logic             sticky_q;
   logic             first_q;
   logic             load_q;
   logic             enable_q;
   logic             valid_q;

   logic             grant_found;
   logic [ID_W-1:0]  grant_idx;
   logic [ID_W-1:0]  cand;

   // Round-robin scan starting at rr_ptr; the accept pulse is only offered in IDLE.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      req_ready   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
      if (!rst && state_q == StIdle && grant_found) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // Run sequencer: IDLE -> LOAD -> RUN -> DONE -> IDLE, with registered control outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         rr_ptr_q <= '0;
         id_q     <= '0;
         start_q  <= '0;
         count_q  <= '0;
         remain_q <= '0;
         sticky_q <= 1'b0;
         first_q  <= 1'b0;
         load_q   <= 1'b0;
         enable_q <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant_found) begin
                  id_q     <= grant_idx;
                  start_q  <= req_start[grant_idx*WIDTH +: WIDTH];
                  remain_q <= req_len[grant_idx*LEN_W +: LEN_W];
                  load_q   <= 1'b1;
                  state_q  <= StLoad;
               end
            end
            StLoad: begin
               load_q   <= 1'b0;
               sticky_q <= 1'b0;
               if (remain_q == '0) begin
                  valid_q <= 1'b1;
                  first_q <= 1'b1;
                  state_q <= StDone;
               end else begin
                  enable_q <= 1'b1;
                  state_q  <= StRun;
               end
            end
            StRun: begin
               if (ctr_overflow) sticky_q <= 1'b1;
               remain_q <= remain_q - 1'b1;
               if (remain_q == LEN_W'(1)) begin
                  enable_q <= 1'b0;
                  valid_q  <= 1'b1;
                  first_q  <= 1'b1;
                  state_q  <= StDone;
               end
            end
            StDone: begin
               first_q <= 1'b0;
               // The counter's last increment only becomes visible on the first DONE cycle.
               if (first_q) begin
                  count_q  <= ctr_count;
                  sticky_q <= sticky_q | ctr_overflow;
               end
               if (done_ready) begin
                  valid_q  <= 1'b0;
                  rr_ptr_q <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                  state_q  <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Result fields: pass the counter through on the first DONE cycle, then hold the capture.
   always_comb begin
      done_count    = first_q ? ctr_count : count_q;
      done_overflow = valid_q & (sticky_q | (first_q & ctr_overflow));
   end

   assign ctr_load       = load_q;
   assign ctr_enable     = enable_q;
   assign ctr_load_value = start_q;
   assign done_valid     = valid_q;
   assign done_id        = id_q;
   assign busy           = (state_q != StIdle);

endmodule
